// File: rtl/vliw_bundle_queue.sv
// Instruction-bundle FIFO between fetch and the per-lane decode stages, with show-ahead head and one-cycle squash.
// Optional feature: define BUNDLE_BYPASS_EN for a zero-latency fetch-to-issue path when the queue is empty.
module vliw_bundle_queue #(
  parameter int                NUM_LANES = 4,
  parameter int                INST_W    = 32,
  parameter int                PC_W      = 32,
  parameter int                DEPTH     = 4,
  parameter logic [INST_W-1:0] NOP_INST  = 32'h00000013
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [PC_W-1:0]               fetch_pc,
  input  logic [NUM_LANES*INST_W-1:0]   fetch_bundle,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [PC_W-1:0]               issue_pc,
  output logic [NUM_LANES*INST_W-1:0]   issue_bundle,
  input  logic                          squash,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BUN_W = NUM_LANES * INST_W;
  localparam int ENT_W = PC_W + BUN_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;

  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [ENT_W-1:0] head_s;
  logic [PC_W-1:0]  issue_pc_s;
  logic [BUN_W-1:0] issue_bundle_s;

`ifdef BUNDLE_BYPASS_EN
  assign bypass_s = empty_q & fetch_valid & ~squash;
`else
  assign bypass_s = 1'b0;
`endif

  assign fetch_ready = ~full_q;
  assign issue_valid = ~empty_q | bypass_s;
  assign push_s      = fetch_valid & fetch_ready;
  assign pop_s       = issue_valid & issue_ready;
  // A bypassed bundle taken by decode in the same cycle never touches storage.
  assign wr_en_s     = push_s & ~squash & ~(bypass_s & issue_ready);
  assign rd_en_s     = pop_s & ~squash & ~bypass_s;
  assign head_s      = mem_q[rd_ptr_q];

  // Head selection: bypass, stored head, or NOP filler with the last PC held.
  always_comb begin
    issue_pc_s     = last_pc_q;
    issue_bundle_s = {NUM_LANES{NOP_INST}};
    if (bypass_s) begin
      issue_pc_s     = fetch_pc;
      issue_bundle_s = fetch_bundle;
    end else if (!empty_q) begin
      issue_pc_s     = head_s[ENT_W-1 -: PC_W];
      issue_bundle_s = head_s[BUN_W-1:0];
    end else begin
      issue_pc_s     = last_pc_q;
      issue_bundle_s = {NUM_LANES{NOP_INST}};
    end
  end

  assign issue_pc     = issue_pc_s;
  assign issue_bundle = issue_bundle_s;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;

  // Pointer, occupancy and status next-state; squash overrides any push or pop.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    last_pc_d = issue_pc_s;
    if (squash) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == {CNT_W{1'b0}});
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q  <= {PTR_W{1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      last_pc_q <= {PC_W{1'b0}};
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Entry storage is pointer-gated and deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {fetch_pc, fetch_bundle};
    end
  end

endmodule

// File: tb/tb_vliw_bundle_queue.sv
// Directed self-checking bench for vliw_bundle_queue: default 4-lane/4-deep instance plus a 2-lane/8-deep instance.
module tb_vliw_bundle_queue;

  logic         clk;
  logic         rst;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [31:0]  fetch_pc;
  logic [127:0] fetch_bundle;
  logic         issue_valid;
  logic         issue_ready;
  logic [31:0]  issue_pc;
  logic [127:0] issue_bundle;
  logic         squash;
  logic [2:0]   count;
  logic         full;
  logic         empty;

  logic         f2_valid;
  logic         f2_ready;
  logic [31:0]  f2_pc;
  logic [63:0]  f2_bundle;
  logic         i2_valid;
  logic         i2_ready;
  logic [31:0]  i2_pc;
  logic [63:0]  i2_bundle;
  logic         sq2;
  logic [3:0]   count2;
  logic         full2;
  logic         empty2;

  int n_checks;
  int n_fail;

  localparam logic [127:0] NOP4 = {4{32'h00000013}};

  vliw_bundle_queue u_dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_bundle(fetch_bundle),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_bundle(issue_bundle),
    .squash(squash), .count(count), .full(full), .empty(empty)
  );

  vliw_bundle_queue #(.NUM_LANES(2), .DEPTH(8)) u_dut2 (
    .clk(clk), .rst(rst),
    .fetch_valid(f2_valid), .fetch_ready(f2_ready),
    .fetch_pc(f2_pc), .fetch_bundle(f2_bundle),
    .issue_valid(i2_valid), .issue_ready(i2_ready),
    .issue_pc(i2_pc), .issue_bundle(i2_bundle),
    .squash(sq2), .count(count2), .full(full2), .empty(empty2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk_bundle(input logic [31:0] pc);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) begin
      b[i*32 +: 32] = 32'hA000_0000 | (pc << 4) | 32'(i);
    end
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch_valid = 1'b0; fetch_pc = 32'h0; fetch_bundle = '0;
    issue_ready = 1'b0; squash = 1'b0;
    f2_valid = 1'b0; f2_pc = 32'h0; f2_bundle = '0; i2_ready = 1'b0; sq2 = 1'b0;
    repeat (3) step();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", issue_valid); end
    n_checks++; if (issue_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", issue_pc); end
    n_checks++; if (issue_bundle !== NOP4) begin n_fail++; $display("FAIL reset_nop got %h exp %h", issue_bundle, NOP4); end
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", fetch_ready); end
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    logic [31:0] pc;
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 16);
      fetch_valid = 1'b1; fetch_pc = pc; fetch_bundle = mk_bundle(pc);
      step();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", count); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full); end
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b exp 0", fetch_ready); end
    fetch_pc = 32'h40; fetch_bundle = mk_bundle(32'h40);
    step();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL overflow_count got %0d exp 4", count); end
    fetch_valid = 1'b0; issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 16);
      n_checks++;
      if (issue_valid !== 1'b1 || issue_pc !== pc || issue_bundle !== mk_bundle(pc)) begin
        n_fail++; $display("FAIL drain_%0d got v=%b pc=%h exp v=1 pc=%h", i, issue_valid, issue_pc, pc);
      end
      step();
    end
    n_checks++; if (empty !== 1'b1 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got e=%b v=%b exp e=1 v=0", empty, issue_valid); end
    n_checks++; if (issue_pc !== 32'h30) begin n_fail++; $display("FAIL drain_pc_hold got %h exp 30", issue_pc); end
    n_checks++; if (issue_bundle !== NOP4) begin n_fail++; $display("FAIL drain_nop got %h exp %h", issue_bundle, NOP4); end
    issue_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    issue_ready = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'h200; fetch_bundle = mk_bundle(32'h200);
    step();
    issue_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      pc = 32'h210 + 32'(k * 16);
      fetch_pc = pc; fetch_bundle = mk_bundle(pc);
      n_checks++;
      if (count !== 3'd1 || issue_pc !== pc - 32'h10 || issue_bundle !== mk_bundle(pc - 32'h10)) begin
        n_fail++; $display("FAIL stream_%0d got cnt=%0d pc=%h exp cnt=1 pc=%h", k, count, issue_pc, pc - 32'h10);
      end
      step();
    end
    fetch_valid = 1'b0;
    n_checks++; if (issue_pc !== 32'h2C0) begin n_fail++; $display("FAIL stream_last got %h exp 2c0", issue_pc); end
    step();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty got %b exp 1", empty); end
    issue_ready = 1'b0;
  endtask

  task automatic test_squash();
    logic [31:0] pc;
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h50 + 32'(i * 16);
      fetch_valid = 1'b1; fetch_pc = pc; fetch_bundle = mk_bundle(pc);
      step();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL sq_pre_count got %0d exp 3", count); end
    fetch_pc = 32'h80; fetch_bundle = mk_bundle(32'h80); squash = 1'b1; issue_ready = 1'b1;
    #1;
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL sq_ready got %b exp 1", fetch_ready); end
    step();
    squash = 1'b0; fetch_valid = 1'b0; issue_ready = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || issue_valid !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL sq_flush got cnt=%0d v=%b e=%b exp cnt=0 v=0 e=1", count, issue_valid, empty);
    end
    n_checks++; if (issue_pc !== 32'h50 || issue_bundle !== NOP4) begin n_fail++; $display("FAIL sq_hold got pc=%h exp 50", issue_pc); end
    fetch_valid = 1'b1; fetch_pc = 32'h100; fetch_bundle = mk_bundle(32'h100);
    step();
    fetch_valid = 1'b0;
    #1;
    n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h100 || count !== 3'd1) begin
      n_fail++; $display("FAIL sq_next got v=%b pc=%h cnt=%0d exp v=1 pc=100 cnt=1", issue_valid, issue_pc, count);
    end
    n_checks++; if (issue_bundle !== mk_bundle(32'h100)) begin n_fail++; $display("FAIL sq_next_bundle got %h exp %h", issue_bundle, mk_bundle(32'h100)); end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
  endtask

  task automatic test_bypass();
    fetch_valid = 1'b1; fetch_pc = 32'h40; fetch_bundle = mk_bundle(32'h40); issue_ready = 1'b1;
    #1;
`ifdef BUNDLE_BYPASS_EN
    n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h40 || issue_bundle !== mk_bundle(32'h40)) begin
      n_fail++; $display("FAIL byp_same got v=%b pc=%h exp v=1 pc=40", issue_valid, issue_pc);
    end
    step();
    fetch_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL byp_after got cnt=%0d v=%b exp 0 0", count, issue_valid); end
`else
    n_checks++; if (issue_valid !== 1'b0 || issue_bundle !== NOP4) begin n_fail++; $display("FAIL nobyp_same got v=%b exp 0", issue_valid); end
    step();
    fetch_valid = 1'b0;
    #1;
    n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h40 || count !== 3'd1) begin
      n_fail++; $display("FAIL nobyp_next got v=%b pc=%h cnt=%0d exp v=1 pc=40 cnt=1", issue_valid, issue_pc, count);
    end
    step();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL nobyp_drain got %b exp 1", empty); end
`endif
    issue_ready = 1'b0;
  endtask

  task automatic test_lanes();
    logic [31:0] lo;
    logic [31:0] hi;
    i2_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f2_valid = 1'b1; f2_pc = 32'(i); f2_bundle = {32'hAAAA_0000 + 32'(i), 32'hBBBB_0000 + 32'(i)};
      step();
    end
    f2_valid = 1'b0;
    n_checks++; if (full2 !== 1'b1 || count2 !== 4'd8 || f2_ready !== 1'b0) begin
      n_fail++; $display("FAIL lanes_full got f=%b cnt=%0d exp f=1 cnt=8", full2, count2);
    end
    i2_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hi = 32'hAAAA_0000 + 32'(i);
      lo = 32'hBBBB_0000 + 32'(i);
      n_checks++;
      if (i2_bundle[63:32] !== hi || i2_bundle[31:0] !== lo || i2_pc !== 32'(i)) begin
        n_fail++; $display("FAIL lanes_%0d got %h pc=%h exp %h%h pc=%0d", i, i2_bundle, i2_pc, hi, lo, i);
      end
      step();
    end
    n_checks++; if (empty2 !== 1'b1 || i2_bundle !== {2{32'h00000013}}) begin n_fail++; $display("FAIL lanes_empty got e=%b %h", empty2, i2_bundle); end
    i2_ready = 1'b0;
  endtask

  task automatic test_reset_midtraffic();
    issue_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h300 + 32'(i * 16); fetch_bundle = mk_bundle(32'h300 + 32'(i * 16));
      step();
    end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid_pre got %0d exp 2", count); end
    fetch_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got cnt=%0d e=%b v=%b exp 0 1 0", count, empty, issue_valid);
    end
    n_checks++; if (issue_bundle !== NOP4 || issue_pc !== 32'h0) begin n_fail++; $display("FAIL mid_reset_out got pc=%h %h", issue_pc, issue_bundle); end
    step();
    #2 rst = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_squash();
    test_bypass();
    test_lanes();
    test_reset_midtraffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
